// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, constants and converter state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp16_pkg;

   localparam int EXP_W   = 5;
   localparam int FRAC_W  = 10;
   localparam int BIAS    = 15;
   localparam int EXP_MAX = 31;

   // Biased exponent at which the implicit-one mantissa already equals the integer.
   localparam int SHIFT_PIVOT = BIAS + FRAC_W;

   localparam logic [2:0] S_WAIT  = 3'd0;
   localparam logic [2:0] S_CLASS = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

endpackage

// File: rtl/fp16_to_int_if.sv
// Strobe handshake bundle between a converter client and fp16_to_int.
// Latency: wires only.
// Backpressure: none; the client must wait for R_O before issuing the next R_I.
interface fp16_to_int_if;
   logic [15:0] dataIn;
   logic        R_I;
   logic [15:0] dataOut;
   logic        R_O;
   logic        ERR;

   modport master (output dataIn, output R_I, input dataOut, input R_O, input ERR);
   modport slave  (input dataIn, input R_I, output dataOut, output R_O, output ERR);
endinterface

// File: rtl/fp16_unpack.sv
// Splits an fp16 word into fields and derives the alignment shift for integer conversion.
// Latency: combinational.
// Backpressure: not applicable.
module fp16_unpack
   import fp16_pkg::*;
(
   input  logic [15:0]       word,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [FRAC_W-1:0] frac,
   output logic              is_special,
   output logic              is_small,
   output logic [3:0]        shift_count,
   output logic              shift_dir
);

   assign sign = word[15];
   assign exp  = word[14:10];
   assign frac = word[9:0];

   // Inf/NaN share the all-ones exponent; anything below the bias has magnitude under one.
   assign is_special = (exp == 5'(EXP_MAX));
   assign is_small   = (exp < 5'(BIAS));

   // Left shift (dir=1) when the unbiased exponent exceeds the fraction width.
   assign shift_dir = (exp > 5'(SHIFT_PIVOT));

   // Distance between exponent and pivot; only meaningful for normal in-range operands.
   always_comb begin
      shift_count = 4'd0;
      if (!is_small && !is_special) begin
         if (exp >= 5'(SHIFT_PIVOT))
            shift_count = 4'(exp - 5'(SHIFT_PIVOT));
         else
            shift_count = 4'(5'(SHIFT_PIVOT) - exp);
      end
   end

endmodule

// File: rtl/fp16_to_int.sv
// Converts fp16 to a signed 16-bit integer, truncating toward zero; flags NaN/Inf/out-of-range.
// Latency: 3+|E-10| cycles for normals, 3 for |x|<1, 2 for Inf/NaN; R_O pulses one cycle.
// Backpressure: none; R_I is only sampled while idle, so requests while busy are dropped.
module fp16_to_int
   import fp16_pkg::*;
#(
   parameter int MAX_MAG = 2048
)(
   input  logic          clk,
   input  logic          reset,
   fp16_to_int_if.slave  bus
);

   localparam logic [16:0] MAX_MAG_V = 17'(MAX_MAG);

   logic [2:0]  state;
   logic [15:0] data_q;
   logic [16:0] mag;
   logic [3:0]  cnt;
   logic        dir_q;
   logic        sign_q;
   logic [15:0] data_out;
   logic        r_o;
   logic        err;

   logic              u_sign;
   logic [EXP_W-1:0]  u_exp;
   logic [FRAC_W-1:0] u_frac;
   logic              u_special;
   logic              u_small;
   logic [3:0]        u_shift_count;
   logic              u_shift_dir;

   fp16_unpack u_unpack (
      .word        (data_q),
      .sign        (u_sign),
      .exp         (u_exp),
      .frac        (u_frac),
      .is_special  (u_special),
      .is_small    (u_small),
      .shift_count (u_shift_count),
      .shift_dir   (u_shift_dir)
   );

   assign bus.dataOut = data_out;
   assign bus.R_O     = r_o;
   assign bus.ERR     = err;

   // Conversion sequencer: classify, align one bit per cycle, range check, report.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_WAIT;
         data_q   <= '0;
         mag      <= '0;
         cnt      <= '0;
         dir_q    <= 1'b0;
         sign_q   <= 1'b0;
         data_out <= '0;
         r_o      <= 1'b0;
         err      <= 1'b0;
      end else begin
         r_o <= 1'b0;
         case (state)
            S_WAIT: begin
               if (bus.R_I) begin
                  data_q   <= bus.dataIn;
                  data_out <= '0;
                  err      <= 1'b0;
                  state    <= S_CLASS;
               end
            end
            S_CLASS: begin
               sign_q <= u_sign;
               if (u_special) begin
                  r_o      <= 1'b1;
                  err      <= 1'b1;
                  data_out <= '0;
                  state    <= S_ERR;
               end else if (u_small) begin
                  mag   <= '0;
                  cnt   <= '0;
                  state <= S_CHECK;
               end else begin
                  mag   <= {6'd0, 1'b1, u_frac};
                  cnt   <= u_shift_count;
                  dir_q <= u_shift_dir;
                  // Exponent exactly at the pivot: mantissa is already the integer.
                  state <= (u_exp == 5'(SHIFT_PIVOT)) ? S_CHECK : S_SHIFT;
               end
            end
            S_SHIFT: begin
               mag <= dir_q ? (mag << 1) : (mag >> 1);
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= S_CHECK;
            end
            S_CHECK: begin
               r_o <= 1'b1;
               if (mag > MAX_MAG_V) begin
                  err      <= 1'b1;
                  data_out <= '0;
                  state    <= S_ERR;
               end else begin
                  data_out <= sign_q ? -mag[15:0] : mag[15:0];
                  state    <= S_DONE;
               end
            end
            S_DONE:  state <= S_WAIT;
            S_ERR:   state <= S_WAIT;
            default: state <= S_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_to_int.sv
// Directed bench for fp16_to_int: values, error flag, exact R_O timing, reset and busy behaviour.
// Latency: measured per conversion against hand-computed cycle counts.
// Backpressure: checks that R_I while busy or in the R_O cycle is dropped.
module tb_fp16_to_int;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   fp16_to_int_if bus();

   fp16_to_int #(.MAX_MAG(2048)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Count R_O pulses over a window of cycles; used to prove nothing unexpected completes.
   task automatic quiet_window(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.R_O === 1'b1) pulses++;
      end
      check_int(tag, pulses, 0);
   endtask

   // One conversion: R_I in cycle T, then measure cycles until R_O and check the result.
   task automatic convert(input string tag, input logic [15:0] din, input logic [15:0] exp_dat,
                          input logic exp_err, input int exp_lat, input bit busy_pulse);
      int lat;
      bit seen;
      @(negedge clk);
      bus.dataIn = din;
      bus.R_I    = 1'b1;
      @(posedge clk);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         bus.R_I = 1'b0;
         if (busy_pulse && lat == 3) begin
            bus.dataIn = 16'h7C00;
            bus.R_I    = 1'b1;
         end
         if (bus.R_O === 1'b1) begin
            seen = 1'b1;
            if (busy_pulse) begin
               bus.dataIn = 16'h7C00;
               bus.R_I    = 1'b1;
            end
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      check_int({tag, "/ro_seen"}, int'(seen), 1);
      check_int({tag, "/latency"}, lat, exp_lat);
      check_val({tag, "/dataOut"}, bus.dataOut, exp_dat);
      check_val({tag, "/err"}, 16'(bus.ERR), 16'(exp_err));
      @(negedge clk);
      bus.R_I = 1'b0;
      check_val({tag, "/ro_pulse_len"}, 16'(bus.R_O), 16'h0000);
      check_val({tag, "/dataOut_hold"}, bus.dataOut, exp_dat);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      reset      = 1'b1;
      bus.R_I    = 1'b0;
      bus.dataIn = 16'h0000;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset/dataOut", bus.dataOut, 16'h0000);
      check_val("reset/ro", 16'(bus.R_O), 16'h0000);
      check_val("reset/err", 16'(bus.ERR), 16'h0000);
      reset = 1'b0;

      convert("pos5",     16'h4500, 16'h0005, 1'b0, 11, 1'b0);
      convert("neg5",     16'hC500, 16'hFFFB, 1'b0, 11, 1'b0);
      convert("neg1p5",   16'hBE00, 16'hFFFF, 1'b0, 13, 1'b0);
      convert("max2048",  16'h6800, 16'h0800, 1'b0, 4,  1'b0);
      convert("over2050", 16'h6801, 16'h0000, 1'b1, 4,  1'b0);
      convert("one",      16'h3C00, 16'h0001, 1'b0, 13, 1'b0);
      convert("below1",   16'h3BFF, 16'h0000, 1'b0, 3,  1'b0);
      convert("negzero",  16'h8000, 16'h0000, 1'b0, 3,  1'b0);
      convert("inf",      16'h7C00, 16'h0000, 1'b1, 2,  1'b0);
      convert("nan",      16'h7E00, 16'h0000, 1'b1, 2,  1'b0);
      convert("max_fp16", 16'h7BFF, 16'h0000, 1'b1, 8,  1'b0);

      // Reset while the 5.0 conversion is in its shift phase.
      @(negedge clk);
      bus.dataIn = 16'h4500;
      bus.R_I    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.R_I = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("midreset/dataOut", bus.dataOut, 16'h0000);
      check_val("midreset/ro", 16'(bus.R_O), 16'h0000);
      check_val("midreset/err", 16'(bus.ERR), 16'h0000);
      reset = 1'b0;
      quiet_window("midreset/no_ro", 15);

      // Busy-time and R_O-cycle requests must be dropped.
      convert("busy12", 16'h4A00, 16'h000C, 1'b0, 10, 1'b1);
      quiet_window("busy/no_extra_ro", 15);
      check_val("busy/err_hold", 16'(bus.ERR), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fp16_to_int.md
Name: fp16_to_int

Overview:
- Converts an IEEE754 half-precision value to a 16-bit two's-complement integer, truncating toward zero.
- It is the decode direction of the integer-to-half converter: the two form a round-trip pair sharing the same R_I/R_O strobe handshake.
- Multi-cycle FSM with an iterative one-bit-per-cycle shifter, a range check, and an error flag for NaN, Inf and out-of-range inputs.

Parameters:
- MAX_MAG, 2048: largest accepted result magnitude, legal range 1..32767. Any larger magnitude is an error.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  16  half-precision operand: [15] sign, [14:10] exponent, [9:0] fraction.
- R_I  input  1  input-valid strobe; sampled only in state S_WAIT.
- dataOut  output  16  signed integer result.
- R_O  output  1  result-ready; one-cycle pulse per conversion.
- ERR  output  1  error flag for the conversion just completed; valid while R_O=1 and held afterwards.

Behaviour:
- Reset (synchronous, active-high): next state is S_WAIT; dataOut=0, R_O=0, ERR=0, all internal registers cleared. Reset overrides any state, including mid-shift; the in-flight conversion is discarded and no R_O is issued for it.
- S_WAIT: if R_I=1 in cycle T, capture dataIn, clear dataOut and ERR, go to S_CLASS. R_I is ignored in every other state, so no queuing.
- S_CLASS (cycle T+1): e=exp field, E=e-15.
  - e=31 (Inf/NaN): go to S_ERR.
  - e<15 (|x|<1, zero and subnormals included): mag=0, n=0, go to S_CHECK.
  - Otherwise: mag={1,frac} in a 17-bit register, n=|E-10|, dir=left if E>10 else right.
  - If n=0, go to S_CHECK; else go to S_SHIFT.
- S_SHIFT (cycles T+2..T+1+n): shift mag one bit per cycle in direction dir and decrement the counter; at zero, go to S_CHECK.
  - Right shifts discard low bits, which truncates.
  - E≤15 gives at most 5 left shifts, so the value fits in 17 bits with no wrap.
- S_CHECK (cycle T+2+n):
  - If mag>MAX_MAG, go to S_ERR.
  - Otherwise dataOut = sign ? -mag[15:0] : mag[15:0]; go to S_DONE.
  - -0.0 and negative values truncated to zero give 0x0000, not an error.
- S_DONE (T+3+n): R_O=1 for exactly this cycle, ERR=0, then S_WAIT.
- S_ERR: R_O=1 for one cycle, ERR=1, dataOut=0, then S_WAIT.
  - Inf/NaN reach S_ERR from S_CLASS, so R_O asserts at T+2.
  - Range errors reach S_ERR from S_CHECK, so R_O asserts at T+3+n.
- Latency from R_I to R_O:
  - Normal inputs: 3+|E-10| cycles; maximum 13, at E=0.
  - |x|<1: 3 cycles.
  - Inf/NaN: 2 cycles.
- dataOut and ERR hold their value until the next R_I is accepted.
- Back-to-back: R_I asserted in the R_O cycle is ignored. The earliest accepted R_I is the cycle after R_O.

Decomposition:
- Shared package fp16_pkg, used by both converter directions:
  - field widths: EXP_W=5, FRAC_W=10;
  - constants: BIAS=15, EXP_MAX=31;
  - state encoding localparams S_WAIT, S_CLASS, S_SHIFT, S_CHECK, S_DONE, S_ERR.
- One sub-module, fp16_unpack (combinational): splits a word into sign/exp/frac and produces flags is_special, is_small, shift_count and shift_dir. The encoder side can reuse it in its self-check.

Test Plan:
- 0x4500 (5.0): E=2, n=8 → dataOut=0x0005, ERR=0, R_O exactly at T+11 and for one cycle only.
- 0xC500 (-5.0) → 0xFFFB. Then 0xBE00 (-1.5) → 0xFFFF, which checks truncation toward zero.
- 0x6800 (2048.0): n=1 → 0x0800 at T+4. Then 0x6801 (2050.0) → ERR=1, dataOut=0x0000 at T+4.
- 0x3C00 (1.0) → 0x0001 at T+13. 0x3BFF and 0x8000 → 0x0000, ERR=0, R_O at T+3.
- 0x7C00 (Inf) and 0x7E00 (NaN) → ERR=1, dataOut=0, R_O at T+2.
- Assert reset during S_SHIFT of 0x4500 → next cycle dataOut=0, R_O=0, ERR=0, and no R_O follows. R_I pulses while busy are ignored. A new conversion of 0x4A00 → 0x000C.
